// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup arbiter.
// Colour RAM geometry, transparency rule, FSM states and the response record.
package palette_pkg;
   localparam int N_PAL    = 4;
   localparam int IDX_W    = 4;
   localparam int COLOR_W  = 24;
   localparam int RSP_ID_W = 2;

   localparam logic [IDX_W-1:0]   TRANSPARENT_IDX   = '0;
   localparam logic [COLOR_W-1:0] TRANSPARENT_COLOR = 24'h000000;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [RSP_ID_W-1:0] id;
      logic [COLOR_W-1:0]  color;
      logic                transp;
   } rsp_t;
endpackage

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr; combinational.
// No backpressure; en=0 suppresses all grants and holds the pointer.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic                 en,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] ptr_nxt
);
   localparam int PW = $clog2(N);

   int j;

   always_comb begin
      gnt     = '0;
      ptr_nxt = ptr;
      j       = 0;
      if (en) begin
         for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (gnt == '0 && req[j]) begin
               gnt[j]  = 1'b1;
               ptr_nxt = PW'((j + 1) % N);
            end
         end
      end
   end
endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shared palette RAM with round-robin lookup arbitration; response latency 2 cycles.
// No response backpressure; cfg writes take priority and block grants for that cycle.
module palette_lookup_arbiter #(
   parameter int N_REQ   = 4,
   parameter int N_PAL   = 4,
   parameter int IDX_W   = 4,
   parameter int COLOR_W = 24
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [N_REQ-1:0]               i_req,
   input  logic [N_REQ*$clog2(N_PAL)-1:0] i_pal,
   input  logic [N_REQ*IDX_W-1:0]         i_idx,
   output logic [N_REQ-1:0]               o_gnt,
   output logic                           o_ready,
   output logic                           o_rsp_valid,
   output logic [$clog2(N_REQ)-1:0]       o_rsp_id,
   output logic [COLOR_W-1:0]             o_rsp_color,
   output logic                           o_rsp_transp,
   input  logic                           i_cfg_we,
   input  logic [$clog2(N_PAL)-1:0]       i_cfg_pal,
   input  logic [IDX_W-1:0]               i_cfg_idx,
   input  logic [COLOR_W-1:0]             i_cfg_color,
   output logic                           o_cfg_ack
);
   import palette_pkg::*;

   localparam int PAL_W  = $clog2(N_PAL);
   localparam int ID_W   = $clog2(N_REQ);
   localparam int ADDR_W = PAL_W + IDX_W;
   localparam int DEPTH  = N_PAL * (1 << IDX_W);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [COLOR_W-1:0]  ram_wdata;
   logic [COLOR_W-1:0]  ram [DEPTH];
   logic [COLOR_W-1:0]  rd_q;

   logic                arb_en;
   logic [N_REQ-1:0]    gnt;
   logic [ID_W-1:0]     ptr_q, ptr_nxt;
   logic [ID_W-1:0]     gnt_id;
   logic [PAL_W-1:0]    sel_pal;
   logic [IDX_W-1:0]    sel_idx;

   logic                s1_vld, s1_transp, s2_vld, s2_transp, cfg_ack_q;
   logic [ID_W-1:0]     s1_id, s2_id;
   logic [ADDR_W-1:0]   s1_addr;
   rsp_t                rsp;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req     (i_req),
      .en      (arb_en),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .ptr_nxt (ptr_nxt)
   );

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      ram_we     = 1'b0;
      ram_waddr  = {i_cfg_pal, i_cfg_idx};
      ram_wdata  = i_cfg_color;
      arb_en     = 1'b0;
      case (state_q)
         INIT: begin
            // Sweep every address once, clearing the RAM, before serving lookups.
            ram_we     = 1'b1;
            ram_waddr  = init_cnt_q;
            ram_wdata  = TRANSPARENT_COLOR;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ADDR_W'(DEPTH - 1))
               state_d = RUN;
         end
         RUN: begin
            ram_we = i_cfg_we;
            arb_en = !i_cfg_we;
         end
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      gnt_id  = '0;
      sel_pal = '0;
      sel_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt[k]) begin
            gnt_id  = ID_W'(k);
            sel_pal = i_pal[k*PAL_W +: PAL_W];
            sel_idx = i_idx[k*IDX_W +: IDX_W];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         ptr_q      <= '0;
         s1_vld     <= 1'b0;
         s1_id      <= '0;
         s1_addr    <= '0;
         s1_transp  <= 1'b0;
         s2_vld     <= 1'b0;
         s2_id      <= '0;
         s2_transp  <= 1'b0;
         cfg_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         ptr_q      <= ptr_nxt;
         s1_vld     <= |gnt;
         s1_id      <= gnt_id;
         s1_addr    <= {sel_pal, sel_idx};
         s1_transp  <= (sel_idx == TRANSPARENT_IDX);
         s2_vld     <= s1_vld;
         s2_id      <= s1_id;
         s2_transp  <= s1_transp;
         cfg_ack_q  <= (state_q == RUN) && i_cfg_we;
      end
   end

   // Read and write share one edge; the read sees the pre-write contents.
   always_ff @(posedge i_clk) begin
      if (ram_we)
         ram[ram_waddr] <= ram_wdata;
      rd_q <= ram[s1_addr];
   end

   always_comb begin
      rsp.id     = s2_id;
      rsp.transp = s2_vld && s2_transp;
      rsp.color  = (s2_vld && !s2_transp) ? rd_q : TRANSPARENT_COLOR;
   end

   assign o_gnt        = gnt;
   assign o_ready      = (state_q == RUN);
   assign o_rsp_valid  = s2_vld;
   assign o_rsp_id     = rsp.id;
   assign o_rsp_color  = rsp.color;
   assign o_rsp_transp = rsp.transp;
   assign o_cfg_ack    = cfg_ack_q;
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Scoreboard bench for palette_lookup_arbiter with a behavioural palette/round-robin model.
// Stimulus process predicts responses; an independent monitor pops and compares them.
module tb_palette_lookup_arbiter;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [3:0]  i_req;
   logic [7:0]  i_pal;
   logic [15:0] i_idx;
   logic [3:0]  o_gnt;
   logic        o_ready;
   logic        o_rsp_valid;
   logic [1:0]  o_rsp_id;
   logic [23:0] o_rsp_color;
   logic        o_rsp_transp;
   logic        i_cfg_we;
   logic [1:0]  i_cfg_pal;
   logic [3:0]  i_cfg_idx;
   logic [23:0] i_cfg_color;
   logic        o_cfg_ack;

   palette_lookup_arbiter dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_req        (i_req),
      .i_pal        (i_pal),
      .i_idx        (i_idx),
      .o_gnt        (o_gnt),
      .o_ready      (o_ready),
      .o_rsp_valid  (o_rsp_valid),
      .o_rsp_id     (o_rsp_id),
      .o_rsp_color  (o_rsp_color),
      .o_rsp_transp (o_rsp_transp),
      .i_cfg_we     (i_cfg_we),
      .i_cfg_pal    (i_cfg_pal),
      .i_cfg_idx    (i_cfg_idx),
      .i_cfg_color  (i_cfg_color),
      .o_cfg_ack    (o_cfg_ack)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [1:0]  id;
      logic [23:0] color;
      logic        transp;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          ack_q[$];
   int          gnt_log[$];
   exp_t        mon_e;

   logic [3:0]  req_v;
   logic [1:0]  pal_a[4];
   logic [3:0]  idx_a[4];
   logic        we_v;
   logic [1:0]  cpal_v;
   logic [3:0]  cidx_v;
   logic [23:0] ccol_v;
   logic [23:0] mem[64];
   int          ptr_m;
   int          init_left;
   bit          auto_drop;
   bit          seen_ready;
   logic [3:0]  dut_gnt;
   int          cyc = 0;
   int          rsp_cnt = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every response must match the oldest prediction, on its predicted cycle.
   always @(negedge i_clk) begin
      if (o_rsp_valid) begin
         rsp_cnt++;
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d color %0h, no response expected (cycle %0d)",
                     o_rsp_id, o_rsp_color, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("rsp_id", 64'(o_rsp_id), 64'(mon_e.id));
            check("rsp_color", 64'(o_rsp_color), 64'(mon_e.color));
            check("rsp_transp", 64'(o_rsp_transp), 64'(mon_e.transp));
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         n_chk++;
         n_fail++;
         $display("FAIL missing_rsp: got no response, expected id %0d at cycle %0d", mon_e.id, mon_e.cyc);
      end
      if (ack_q.size() > 0 && ack_q[0] == cyc) begin
         check("cfg_ack", 64'(o_cfg_ack), 64'd1);
         void'(ack_q.pop_front());
      end else begin
         check("cfg_ack", 64'(o_cfg_ack), 64'd0);
      end
   end

   // One clock cycle: drive, predict and check at negedge, then advance the model.
   task automatic step();
      logic [3:0] exp_gnt;
      int         k_g;
      int         j;
      exp_t       e;
      i_req = req_v;
      for (int k = 0; k < 4; k++) begin
         i_pal[k*2 +: 2] = pal_a[k];
         i_idx[k*4 +: 4] = idx_a[k];
      end
      i_cfg_we    = we_v;
      i_cfg_pal   = cpal_v;
      i_cfg_idx   = cidx_v;
      i_cfg_color = ccol_v;
      @(negedge i_clk);
      exp_gnt = '0;
      k_g     = -1;
      if (init_left == 0 && !i_rst && !we_v) begin
         for (int i = 0; i < 4; i++) begin
            j = (ptr_m + i) % 4;
            if (k_g < 0 && req_v[j]) k_g = j;
         end
      end
      if (k_g >= 0) exp_gnt[k_g] = 1'b1;
      check("gnt", 64'(o_gnt), 64'(exp_gnt));
      check("ready", 64'(o_ready), 64'(init_left == 0 && !i_rst));
      seen_ready = o_ready;
      dut_gnt    = o_gnt;
      if (k_g >= 0) begin
         e.id     = 2'(k_g);
         e.transp = (idx_a[k_g] == 4'd0);
         e.color  = e.transp ? 24'h000000 : mem[{pal_a[k_g], idx_a[k_g]}];
         e.cyc    = cyc + 2;
         sb.push_back(e);
         ptr_m = (k_g + 1) % 4;
      end
      if (init_left == 0 && !i_rst && we_v) begin
         mem[{cpal_v, cidx_v}] = ccol_v;
         ack_q.push_back(cyc + 1);
      end
      if (!i_rst && init_left > 0) init_left--;
      @(posedge i_clk);
      #1;
      if (k_g >= 0) begin
         if (auto_drop) begin
            req_v[k_g] = 1'b0;
         end else begin
            pal_a[k_g] = 2'($urandom_range(0, 3));
            idx_a[k_g] = 4'($urandom_range(0, 15));
         end
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      sb.delete();
      ack_q.delete();
      ptr_m     = 0;
      init_left = 64;
      for (int a = 0; a < 64; a++) mem[a] = 24'h0;
      repeat (3) step();
      i_rst = 1'b0;
   endtask

   task automatic wait_ready(input string nm);
      int n;
      n          = 0;
      seen_ready = 1'b0;
      while (!seen_ready && n < 200) begin
         step();
         n++;
      end
      check(nm, 64'(n), 64'd65);
   endtask

   task automatic wait_granted(input int bound);
      int n;
      n = 0;
      while (req_v != 4'b0 && n < bound) begin
         step();
         n++;
      end
      check("grant_timeout_pending_req", 64'(req_v), 64'd0);
   endtask

   task automatic cfg_write(input logic [1:0] p, input logic [3:0] ix, input logic [23:0] c);
      we_v   = 1'b1;
      cpal_v = p;
      cidx_v = ix;
      ccol_v = c;
      step();
      we_v   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int base;
      i_rst     = 1'b1;
      req_v     = '0;
      we_v      = 1'b0;
      cpal_v    = '0;
      cidx_v    = '0;
      ccol_v    = '0;
      auto_drop = 1'b1;
      for (int k = 0; k < 4; k++) begin
         pal_a[k] = 2'd2;
         idx_a[k] = 4'd5;
      end
      @(posedge i_clk);
      #1;

      // Init with all requesters waiting on pal 2 / idx 5.
      req_v = 4'b1111;
      do_reset();
      wait_ready("init_cycles_to_ready");
      wait_granted(20);

      // Write then read back through requester 2.
      cfg_write(2'd1, 4'd3, 24'h484b4d);
      req_v[2] = 1'b1;
      pal_a[2] = 2'd1;
      idx_a[2] = 4'd3;
      wait_granted(10);

      // Round-robin from pointer 0 with all requesters held high.
      req_v = 4'b1000;
      wait_granted(10);
      auto_drop = 1'b0;
      req_v     = 4'b1111;
      gnt_log.delete();
      repeat (8) begin
         step();
         base = -1;
         for (int i = 3; i >= 0; i--) if (dut_gnt[i]) base = i;
         gnt_log.push_back(base);
      end
      req_v     = 4'b0;
      auto_drop = 1'b1;
      check("rr_log_len", 64'(gnt_log.size()), 64'd8);
      for (int i = 0; i < gnt_log.size(); i++) check("rr_order", 64'(gnt_log[i]), 64'(i % 4));
      repeat (3) step();

      // Config writes block grants; the pointer must not move.
      req_v = 4'b0101;
      cnt   = 0;
      for (int i = 0; i < 3; i++) begin
         we_v   = 1'b1;
         cpal_v = 2'd3;
         cidx_v = 4'(i + 1);
         ccol_v = 24'($urandom);
         step();
         if (dut_gnt != 4'b0) cnt++;
      end
      we_v = 1'b0;
      check("wp_grants_during_write", 64'(cnt), 64'd0);
      step();
      check("wp_resume_gnt", 64'(dut_gnt), 64'b0001);
      wait_granted(10);

      // Index 0 is transparent regardless of stored colour.
      cfg_write(2'd0, 4'd0, 24'hffffff);
      req_v[1] = 1'b1;
      pal_a[1] = 2'd0;
      idx_a[1] = 4'd0;
      wait_granted(10);

      // Read-before-write hazard on the same address.
      cfg_write(2'd2, 4'd7, 24'habcdef);
      req_v    = 4'b0001;
      pal_a[0] = 2'd2;
      idx_a[0] = 4'd7;
      step();
      cfg_write(2'd2, 4'd7, 24'h123456);
      req_v[0] = 1'b1;
      wait_granted(10);

      // Randomised traffic with interleaved config writes.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (!req_v[k] && $urandom_range(0, 2) == 0) begin
               req_v[k] = 1'b1;
               pal_a[k] = 2'($urandom_range(0, 3));
               idx_a[k] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
         end
         we_v   = ($urandom_range(0, 7) == 0);
         cpal_v = 2'($urandom_range(0, 3));
         cidx_v = 4'($urandom_range(0, 15));
         ccol_v = 24'($urandom);
         step();
      end
      we_v = 1'b0;
      wait_granted(50);
      repeat (3) step();

      // Reset at init cycle 30 restarts the full sweep; writes during init are ignored.
      do_reset();
      we_v   = 1'b1;
      ccol_v = 24'h55aa55;
      repeat (30) step();
      we_v = 1'b0;
      do_reset();
      wait_ready("reinit_cycles_to_ready");

      // Reset one cycle after a grant discards the in-flight response.
      req_v    = 4'b0001;
      pal_a[0] = 2'd1;
      idx_a[0] = 4'd3;
      step();
      base = rsp_cnt;
      do_reset();
      wait_ready("pipe_reset_cycles_to_ready");
      check("pipe_reset_rsp_count", 64'(rsp_cnt - base), 64'd0);

      repeat (4) step();
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      check("ack_queue_empty", 64'(ack_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
